pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Game-control FSM for the Pong design. It consumes the hit/miss pulses produced by the graphics block and returns the gra_still freeze control to it. It keeps a 2-digit BCD score, the remaining-ball count and a frame-based delay timer. It also drives the text-overlay selects (rules, game over).

Parameters:
BALLS, 3, balls per game (1..3, fits ball_cnt width)
TIMER_TICKS, 120, delay in frame ticks after miss/game over (2 s at 60 Hz); 7-bit
REFR_Y, 481, pix_y value at which the frame tick fires (with pix_x==0)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
pix_x  in  10  current scan x from sync generator
pix_y  in  10  current scan y from sync generator
btn  in  2  paddle buttons (up/down), synchronous, level
hit  in  1  ball-on-paddle level from graphics (stays high for up to a frame)
miss  in  1  ball-past-right-border level from graphics (stays high while out)
gra_still  out  1  1 = graphics freeze ball/paddle at start position
show_rule  out  1  rules text enable
show_over  out  1  game-over text enable
dig1  out  4  score tens, BCD
dig0  out  4  score units, BCD
ball_cnt  out  2  balls remaining including the one in play
timer_up  out  1  delay timer at zero

Behaviour:
- Reset (asynchronous, any time, including mid-game): state=NEWGAME, dig1=dig0=0, ball_cnt=BALLS, timer=0, edge registers=0.
- Reset outputs: gra_still=1, show_rule=1, show_over=0, timer_up=1.
- refr_tick = (pix_y==REFR_Y)&&(pix_x==0), combinational; exactly 1 clk per frame.
- Edge detect: hit_d, miss_d, btn_d registered each clk.
  - hit_re = hit & ~hit_d; miss_re = miss & ~miss_d; start = (|btn) & ~btn_d.
  - A level held across many cycles counts once.
- Timer: 7-bit down counter.
  - Loads TIMER_TICKS on the clk that enters NEWBALL or OVER.
  - Otherwise decrements on refr_tick while nonzero; holds at 0.
  - timer_up = (timer==0).
- States (Moore outputs):
  - NEWGAME: gra_still=1, show_rule=1. On start: dig1=dig0=0, ball_cnt=BALLS, next PLAY.
  - PLAY: gra_still=0. On hit_re (and not miss_re): score +1 in BCD.
    - dig0==9 -> dig0=0 and dig1+1.
    - 99 wraps to 00.
    - On miss_re: if ball_cnt==1, then ball_cnt=0, load timer, next OVER; else ball_cnt-1, load timer, next NEWBALL.
    - miss_re has priority over a simultaneous hit_re; that hit is not scored.
  - NEWBALL: gra_still=1. When timer_up & start -> PLAY. A start before expiry is ignored, not queued.
  - OVER: gra_still=1, show_over=1. When timer_up -> NEWGAME, no button required. Score is held for display until the next start.
- hit/miss outside PLAY: ignored, but edge registers still track so no stale edge fires on entering PLAY.
- State changes take effect on the clk after the qualifying edge. Outputs are registered state decodes (1-clk latency).

Decomposition:
- Shared package: state encoding constants (NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3), REFR_Y, default TIMER_TICKS and BALLS, so the graphics/text blocks decode the same values.
- One natural sub-module: pong_bcd_score (2-digit BCD counter with clear/inc, wrap at 99).
- Timer and FSM stay in the top module.

Test Plan:
- Reset mid-PLAY with score 0x12, ball_cnt=2 -> same clk: state NEWGAME, dig1/dig0=0/0, ball_cnt=3, gra_still=1, show_rule=1.
- NEWGAME, btn=2'b01 held 500 clks -> one transition to PLAY, gra_still=0. hit held 800 clks -> score 01, not 800.
- Score at 09 then hit pulse -> 10. Preload 99 then hit pulse -> 00, dig1=0.
- PLAY with ball_cnt=3, miss pulse -> NEWBALL, ball_cnt=2, timer=120, timer_up=0.
  - btn at tick 50 -> stays NEWBALL.
  - After 120 refr_ticks, btn -> PLAY.
- ball_cnt=1, miss -> OVER, show_over=1, ball_cnt=0. After 120 refr_ticks -> NEWGAME automatically, score retained until next start.
- hit and miss rising on the same clk in PLAY -> score unchanged, ball_cnt decremented, state NEWBALL.

Source files
------------

// File: rtl/pong_game_ctrl_pkg.sv
// Shared Pong game-control definitions: state encoding, timing defaults and BCD helper.
// Graphics and text blocks import this so that they decode the same state values.
package pong_game_ctrl_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  localparam int unsigned DEF_REFR_Y      = 481;
  localparam int unsigned DEF_TIMER_TICKS = 120;
  localparam int unsigned DEF_BALLS       = 3;
  localparam int unsigned TIMER_W         = 7;

  // Two-digit BCD increment; 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [3:0] d1, input logic [3:0] d0);
    logic [3:0] n1;
    logic [3:0] n0;
    if (d0 == 4'd9) begin
      n0 = 4'd0;
      n1 = (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
    end else begin
      n0 = d0 + 4'd1;
      n1 = d1;
    end
    return {n1, n0};
  endfunction

endpackage

// File: rtl/pong_bcd_score.sv
// Two-digit BCD score counter with synchronous clear and increment.
module pong_bcd_score
  import pong_game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig1,
  output logic [3:0] dig0
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig1 <= '0;
      dig0 <= '0;
    end else if (clr) begin
      dig1 <= '0;
      dig0 <= '0;
    end else if (inc) begin
      {dig1, dig0} <= bcd_inc(dig1, dig0);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-control FSM: edge-detected hit/miss/button, score, ball count
// and frame-based delay timer; drives graphics freeze and text selects.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter int unsigned BALLS       = DEF_BALLS,
  parameter int unsigned TIMER_TICKS = DEF_TIMER_TICKS,
  parameter int unsigned REFR_Y      = DEF_REFR_Y
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic       gra_still,
  output logic       show_rule,
  output logic       show_over,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic [1:0] ball_cnt,
  output logic       timer_up
);

  game_state_t        state_q, state_d;
  logic [TIMER_W-1:0] timer_q;
  logic               hit_d, miss_d, btn_d;
  logic               hit_re, miss_re, start, refr_tick;
  logic               score_clr, score_inc, ball_load, ball_dec, timer_load;

  assign refr_tick = (pix_y == 10'(REFR_Y)) && (pix_x == '0);
  assign hit_re    = hit & ~hit_d;
  assign miss_re   = miss & ~miss_d;
  assign start     = (|btn) & ~btn_d;

  // Edge registers track in every state so no stale edge fires on entering PLAY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_d  <= 1'b0;
      miss_d <= 1'b0;
      btn_d  <= 1'b0;
    end else begin
      hit_d  <= hit;
      miss_d <= miss;
      btn_d  <= |btn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= NEWGAME;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    ball_load  = 1'b0;
    ball_dec   = 1'b0;
    timer_load = 1'b0;
    case (state_q)
      NEWGAME: begin
        if (start) begin
          score_clr = 1'b1;
          ball_load = 1'b1;
          state_d   = PLAY;
        end
      end
      PLAY: begin
        // A miss wins over a simultaneous hit, which is then not scored.
        if (miss_re) begin
          timer_load = 1'b1;
          ball_dec   = 1'b1;
          state_d    = (ball_cnt == 2'd1) ? OVER : NEWBALL;
        end else if (hit_re) begin
          score_inc = 1'b1;
        end
      end
      NEWBALL: begin
        if (timer_up && start) state_d = PLAY;
      end
      OVER: begin
        if (timer_up) state_d = NEWGAME;
      end
      default: state_d = NEWGAME;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_cnt <= 2'(BALLS);
    end else if (ball_load) begin
      ball_cnt <= 2'(BALLS);
    end else if (ball_dec) begin
      ball_cnt <= ball_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (timer_load) begin
      timer_q <= TIMER_W'(TIMER_TICKS);
    end else if (refr_tick && (timer_q != '0)) begin
      timer_q <= timer_q - 1'b1;
    end
  end

  pong_bcd_score u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .dig1  (dig1),
    .dig0  (dig0)
  );

  assign timer_up  = (timer_q == '0);
  assign gra_still = (state_q != PLAY);
  assign show_rule = (state_q == NEWGAME);
  assign show_over = (state_q == OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed game scenario plus random play
// compared every cycle against a behavioural game model.
module tb_pong_game_ctrl;

  localparam int M_TICKS = 120;
  localparam int M_BALLS = 3;
  localparam int M_NEWGAME = 0, M_PLAY = 1, M_NEWBALL = 2, M_OVER = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] pix_x = 10'd5;
  logic [9:0] pix_y = 10'd10;
  logic [1:0] btn = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still, show_rule, show_over, timer_up;
  logic [3:0] dig1, dig0;
  logic [1:0] ball_cnt;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Game model: mode, score as an integer 0..99, balls left, delay ticks left.
  int m_mode, m_score, m_balls, m_timer;
  bit p_hit, p_miss, p_btn;

  pong_game_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .btn       (btn),
    .hit       (hit),
    .miss      (miss),
    .gra_still (gra_still),
    .show_rule (show_rule),
    .show_over (show_over),
    .dig1      (dig1),
    .dig0      (dig0),
    .ball_cnt  (ball_cnt),
    .timer_up  (timer_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = M_NEWGAME; m_score = 0; m_balls = M_BALLS; m_timer = 0;
      p_hit = 0; p_miss = 0; p_btn = 0;
    end else begin
      bit hre, mre, st, tk;
      int t_old;
      hre   = hit && !p_hit;
      mre   = miss && !p_miss;
      st    = (btn != 2'b00) && !p_btn;
      tk    = (pix_y == 10'd481) && (pix_x == 10'd0);
      t_old = m_timer;
      if (m_mode == M_PLAY && mre) m_timer = M_TICKS;
      else if (tk && m_timer > 0) m_timer = m_timer - 1;
      case (m_mode)
        M_NEWGAME: if (st) begin m_score = 0; m_balls = M_BALLS; m_mode = M_PLAY; end
        M_PLAY: begin
          if (mre) begin
            m_balls = m_balls - 1;
            m_mode = (m_balls == 0) ? M_OVER : M_NEWBALL;
          end else if (hre) m_score = (m_score + 1) % 100;
        end
        M_NEWBALL: if (t_old == 0 && st) m_mode = M_PLAY;
        default:   if (t_old == 0) m_mode = M_NEWGAME;
      endcase
      p_hit = hit; p_miss = miss; p_btn = (btn != 2'b00);
    end
    #1;
    if (chk_en) begin
      check("gra_still", 8'(gra_still), 8'(m_mode != M_PLAY));
      check("show_rule", 8'(show_rule), 8'(m_mode == M_NEWGAME));
      check("show_over", 8'(show_over), 8'(m_mode == M_OVER));
      check("ball_cnt", 8'(ball_cnt), 8'(m_balls));
      check("dig1", 8'(dig1), 8'(m_score / 10));
      check("dig0", 8'(dig0), 8'(m_score % 10));
      check("timer_up", 8'(timer_up), 8'(m_timer == 0));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_hit(input int n);
    repeat (n) begin hit = 1'b1; cyc(1); hit = 1'b0; cyc(1); end
  endtask

  task automatic pulse_miss();
    miss = 1'b1; cyc(1); miss = 1'b0; cyc(1);
  endtask

  task automatic press();
    btn = 2'b01; cyc(1); btn = 2'b00; cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      pix_x = 10'd0; pix_y = 10'd481; cyc(1);
      pix_x = 10'd5; pix_y = 10'd10;  cyc(1);
    end
  endtask

  initial begin
    #2 reset = 1'b1;
    chk_en = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("rst_gra_still", 8'(gra_still), 8'd1);
    check("rst_show_rule", 8'(show_rule), 8'd1);
    check("rst_show_over", 8'(show_over), 8'd0);
    check("rst_timer_up", 8'(timer_up), 8'd1);
    check("rst_ball_cnt", 8'(ball_cnt), 8'd3);

    // Held button starts exactly one game; held hit scores once.
    btn = 2'b01; cyc(500); btn = 2'b00; cyc(1);
    check("start_play", 8'(gra_still), 8'd0);
    hit = 1'b1; cyc(800); hit = 1'b0; cyc(1);
    check("held_hit", 8'({dig1, dig0}), 8'h01);
    pulse_hit(8);
    check("score_09", 8'({dig1, dig0}), 8'h09);
    pulse_hit(1);
    check("score_10", 8'({dig1, dig0}), 8'h10);

    pulse_miss();
    check("nb_ball_cnt", 8'(ball_cnt), 8'd2);
    check("nb_timer_up", 8'(timer_up), 8'd0);
    check("nb_still", 8'(gra_still), 8'd1);
    ticks(50);
    press();
    check("early_btn", 8'(gra_still), 8'd1);
    ticks(69);
    check("timer_119", 8'(timer_up), 8'd0);
    ticks(1);
    check("timer_120", 8'(timer_up), 8'd1);
    press();
    check("nb_resume", 8'(gra_still), 8'd0);

    pulse_hit(89);
    check("score_99", 8'({dig1, dig0}), 8'h99);
    pulse_hit(1);
    check("score_wrap", 8'({dig1, dig0}), 8'h00);
    pulse_hit(2);

    hit = 1'b1; miss = 1'b1; cyc(1); hit = 1'b0; miss = 1'b0; cyc(1);
    check("hm_score", 8'({dig1, dig0}), 8'h02);
    check("hm_ball_cnt", 8'(ball_cnt), 8'd1);
    check("hm_still", 8'(gra_still), 8'd1);
    ticks(120);
    press();
    pulse_miss();
    check("over_show", 8'(show_over), 8'd1);
    check("over_balls", 8'(ball_cnt), 8'd0);
    ticks(120);
    check("over_to_new", 8'(show_rule), 8'd1);
    check("over_score_kept", 8'({dig1, dig0}), 8'h02);
    press();
    check("new_score", 8'({dig1, dig0}), 8'h00);
    check("new_balls", 8'(ball_cnt), 8'd3);

    pulse_hit(12);
    pulse_miss();
    ticks(120);
    press();
    check("pre_rst_score", 8'({dig1, dig0}), 8'h12);
    check("pre_rst_balls", 8'(ball_cnt), 8'd2);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_score", 8'({dig1, dig0}), 8'h00);
    check("mid_rst_balls", 8'(ball_cnt), 8'd3);
    check("mid_rst_still", 8'(gra_still), 8'd1);
    check("mid_rst_rule", 8'(show_rule), 8'd1);
    cyc(1);
    reset = 1'b0;
    cyc(1);

    // Random play; the model process checks every cycle.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(7) == 0) hit = ~hit;
      if ($urandom_range(15) == 0) miss = ~miss;
      if ($urandom_range(9) == 0) btn = 2'($urandom_range(3));
      pix_x = ($urandom_range(3) == 0) ? 10'd1 : 10'd0;
      pix_y = ($urandom_range(1) == 0) ? 10'd481 : 10'd480;
      if ($urandom_range(2999) == 0) begin
        #2 reset = 1'b1;
        cyc(1);
        reset = 1'b0;
      end else begin
        cyc(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
